// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode field, HALT encoding,
// IF/ID bundle and the fetch-stage state encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [5:0]  opcode_t;

   localparam opcode_t HALT = 6'b111111;

   typedef struct packed {
      word_t instr;
      word_t npc;
      logic  valid;
   } if_id_t;

   typedef enum logic [1:0] {
      FETCH      = 2'd0,
      REDIR_PEND = 2'd1,
      HALTED     = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline latch: flush inserts a bubble and beats en,
// en captures a fetched word, otherwise the latch holds.
module if_id_reg
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        en,
   input  logic        flush,
   input  logic [31:0] instr,
   input  logic [31:0] npc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_npc,
   output logic        ifid_valid
);

   if_id_t q;

   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         q <= '0;
      end else if (en) begin
         q <= '{instr: instr, npc: npc, valid: 1'b1};
      end
   end

   assign ifid_instr = q.instr;
   assign ifid_npc   = q.npc;
   assign ifid_valid = q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the
// fetch FSM that parks a redirect across an icache miss.
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        hazard,
   input  logic        branch,
   input  logic        jump,
   input  logic [31:0] redirect_pc,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_npc,
   output logic        ifid_valid,
   output logic        fetch_halted
);

   fetch_state_t state;
   word_t        pc;
   word_t        tgt_q;
   word_t        pc_plus4;

   logic redir;
   logic accept;
   logic is_halt;
   logic take;
   logic park;
   logic stop;
   logic step;
   logic en;
   logic flush;

   assign redir    = (branch | jump) & ~hazard;
   assign accept   = ihit & ~hazard;
   assign is_halt  = (imemload[31:26] == HALT);
   assign pc_plus4 = pc + 32'd4;

   // Mutually exclusive FETCH actions; hazard makes them all zero.
   assign take = redir & ihit;
   assign park = redir & ~ihit;
   assign stop = accept & ~redir & is_halt;
   assign step = accept & ~redir & ~is_halt;

   assign imemaddr = pc;
   assign imemREN  = ~RST & (state != HALTED);

   always_comb begin
      en    = 1'b0;
      flush = 1'b0;
      unique case (state)
         FETCH: begin
            en    = accept;
            flush = redir | (~ihit & ~hazard);
         end
         REDIR_PEND: flush = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc           <= PC_RESET;
         tgt_q        <= '0;
         state        <= FETCH;
         fetch_halted <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               unique case (1'b1)
                  take: pc <= redirect_pc;
                  park: begin
                     tgt_q <= redirect_pc;
                     state <= REDIR_PEND;
                  end
                  stop: begin
                     fetch_halted <= 1'b1;
                     state        <= HALTED;
                  end
                  step: pc <= pc_plus4;
                  default: ;
               endcase
            end
            REDIR_PEND: begin
               // Address stays stable until the miss returns.
               if (accept) begin
                  pc    <= redir ? redirect_pc : tgt_q;
                  state <= FETCH;
               end else if (redir) begin
                  tgt_q <= redirect_pc;
               end
            end
            HALTED: ;
            default: state <= FETCH;
         endcase
      end
   end

   if_id_reg u_if_id (
      .CLK        (CLK),
      .RST        (RST),
      .en         (en),
      .flush      (flush),
      .instr      (imemload),
      .npc        (pc_plus4),
      .ifid_instr (ifid_instr),
      .ifid_npc   (ifid_npc),
      .ifid_valid (ifid_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage, plus a wrap-around
// instance reset to the top of the address space.
module tb_fetch_stage;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst, ihit, hazard, branch, jump;
   logic [31:0] load, rpc;
   logic        ren, valid, halted;
   logic [31:0] addr, instr, npc;

   logic        b_rst, b_ihit;
   logic [31:0] b_load;
   logic        b_ren, b_valid, b_halted;
   logic [31:0] b_addr, b_instr, b_npc;

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .CLK(CLK), .RST(rst), .ihit(ihit), .imemload(load),
      .hazard(hazard), .branch(branch), .jump(jump),
      .redirect_pc(rpc), .imemREN(ren), .imemaddr(addr),
      .ifid_instr(instr), .ifid_npc(npc), .ifid_valid(valid),
      .fetch_halted(halted)
   );

   fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) dut_w (
      .CLK(CLK), .RST(b_rst), .ihit(b_ihit), .imemload(b_load),
      .hazard(1'b0), .branch(1'b0), .jump(1'b0),
      .redirect_pc(32'h0), .imemREN(b_ren), .imemaddr(b_addr),
      .ifid_instr(b_instr), .ifid_npc(b_npc), .ifid_valid(b_valid),
      .fetch_halted(b_halted)
   );

   typedef struct {
      logic        rst, ihit, hz, br, jp;
      logic [31:0] load, rpc;
      logic        ren;
      logic [31:0] addr, instr, npc;
      logic        valid, halted;
   } vec_t;

   vec_t vq[$];

   localparam logic [31:0] HW = 32'hFC00_0000;
   localparam logic [31:0] JK = 32'h2BAD_0000;

   task automatic add(
      input logic r, input logic ih, input logic hz,
      input logic br, input logic jp,
      input logic [31:0] ld, input logic [31:0] tp,
      input logic en, input logic [31:0] ea,
      input logic [31:0] ei, input logic [31:0] enp,
      input logic ev, input logic eh);
      vec_t v;
      v = '{r, ih, hz, br, jp, ld, tp, en, ea, ei, enp, ev, eh};
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int row,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row%0d got=%h want=%h", nm, row, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; ihit = 1'b0; hazard = 1'b0; branch = 1'b0;
      jump = 1'b0; load = '0; rpc = '0;
      b_rst = 1'b1; b_ihit = 1'b0; b_load = '0;

      // reset
      add(1,0,0,0,0, 0,0,         0,32'h0,  0,0,0,0);
      // sequential fetch
      add(0,1,0,0,0, 32'h2001_0000,0, 1,32'h4, 32'h2001_0000,32'h4,1,0);
      add(0,1,0,0,0, 32'h2002_0000,0, 1,32'h8, 32'h2002_0000,32'h8,1,0);
      // hazard holds PC and IF/ID
      add(0,1,1,0,0, JK,0,        1,32'h8,  32'h2002_0000,32'h8,1,0);
      add(0,1,1,0,0, JK,0,        1,32'h8,  32'h2002_0000,32'h8,1,0);
      add(0,1,1,0,0, JK,0,        1,32'h8,  32'h2002_0000,32'h8,1,0);
      add(0,1,0,0,0, 32'h2003_0000,0, 1,32'hC, 32'h2003_0000,32'hC,1,0);
      // branch with hit
      add(0,1,0,1,0, JK,32'h40,   1,32'h40, 0,0,0,0);
      add(0,1,0,0,0, 32'h2004_0000,0, 1,32'h44, 32'h2004_0000,32'h44,1,0);
      // plain miss
      add(0,0,0,0,0, 0,0,         1,32'h44, 0,0,0,0);
      // jump during miss
      add(0,0,0,0,1, 0,32'h80,    1,32'h44, 0,0,0,0);
      add(0,0,0,0,0, 0,0,         1,32'h44, 0,0,0,0);
      add(0,0,0,0,0, 0,0,         1,32'h44, 0,0,0,0);
      add(0,0,0,0,0, 0,0,         1,32'h44, 0,0,0,0);
      add(0,1,0,0,0, JK,0,        1,32'h80, 0,0,0,0);
      add(0,1,0,0,0, 32'h2005_0000,0, 1,32'h84, 32'h2005_0000,32'h84,1,0);
      // newest pending target wins
      add(0,0,0,1,0, 0,32'h100,   1,32'h84, 0,0,0,0);
      add(0,0,0,0,1, 0,32'h200,   1,32'h84, 0,0,0,0);
      add(0,1,0,0,0, JK,0,        1,32'h200,0,0,0,0);
      add(0,1,0,0,0, 32'h2006_0000,0, 1,32'h204, 32'h2006_0000,32'h204,1,0);
      // reset mid pending redirect
      add(0,0,0,0,1, 0,32'h300,   1,32'h204,0,0,0,0);
      add(1,0,0,0,0, 0,0,         0,32'h0,  0,0,0,0);
      add(0,0,0,0,0, 0,0,         1,32'h0,  0,0,0,0);
      add(0,1,0,0,0, 32'h2007_0000,0, 1,32'h4, 32'h2007_0000,32'h4,1,0);
      add(0,1,0,0,0, 32'h2008_0000,0, 1,32'h8, 32'h2008_0000,32'h8,1,0);
      add(0,1,0,0,0, 32'h2009_0000,0, 1,32'hC, 32'h2009_0000,32'hC,1,0);
      add(0,1,0,0,0, 32'h200A_0000,0, 1,32'h10,32'h200A_0000,32'h10,1,0);
      // HALT at 0x10
      add(0,1,0,0,0, HW,0,        0,32'h10, HW,32'h14,1,1);
      add(0,1,0,1,0, JK,32'h40,   0,32'h10, HW,32'h14,1,1);
      add(0,1,0,0,0, 32'h2001_0000,0, 0,32'h10, HW,32'h14,1,1);
      // HALT in branch shadow is squashed
      add(1,0,0,0,0, 0,0,         0,32'h0,  0,0,0,0);
      add(0,1,0,0,0, 32'h2001_0000,0, 1,32'h4, 32'h2001_0000,32'h4,1,0);
      add(0,1,0,0,0, 32'h2002_0000,0, 1,32'h8, 32'h2002_0000,32'h8,1,0);
      add(0,1,0,0,0, 32'h2003_0000,0, 1,32'hC, 32'h2003_0000,32'hC,1,0);
      add(0,1,0,0,0, 32'h2004_0000,0, 1,32'h10,32'h2004_0000,32'h10,1,0);
      add(0,1,0,1,0, HW,32'h60,   1,32'h60, 0,0,0,0);
      add(0,1,0,0,0, 32'h200F_0000,0, 1,32'h64, 32'h200F_0000,32'h64,1,0);

      for (int i = 0; i < vq.size(); i++) begin
         rst    = vq[i].rst;
         ihit   = vq[i].ihit;
         hazard = vq[i].hz;
         branch = vq[i].br;
         jump   = vq[i].jp;
         load   = vq[i].load;
         rpc    = vq[i].rpc;
         @(posedge CLK);
         #1;
         chk("imemREN",      i, {31'b0, ren},    {31'b0, vq[i].ren});
         chk("imemaddr",     i, addr,            vq[i].addr);
         chk("ifid_instr",   i, instr,           vq[i].instr);
         chk("ifid_npc",     i, npc,             vq[i].npc);
         chk("ifid_valid",   i, {31'b0, valid},  {31'b0, vq[i].valid});
         chk("fetch_halted", i, {31'b0, halted}, {31'b0, vq[i].halted});
      end

      // wrap-around instance held in reset so far
      chk("wrap_rst_addr", 0, b_addr, 32'hFFFF_FFFC);
      chk("wrap_rst_ren",  0, {31'b0, b_ren}, 32'h0);
      b_rst  = 1'b0;
      b_ihit = 1'b1;
      b_load = 32'h1234_5678;
      @(posedge CLK);
      #1;
      chk("wrap_addr",  1, b_addr,  32'h0);
      chk("wrap_npc",   1, b_npc,   32'h0);
      chk("wrap_instr", 1, b_instr, 32'h1234_5678);
      chk("wrap_valid", 1, {31'b0, b_valid}, 32'h1);
      chk("wrap_halt",  1, {31'b0, b_halted}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
